// File: rtl/multi_operand_adder_pipe.sv
// Pipelined sum of NUM_IN unsigned operands plus a constant OFFSET through a registered
// binary adder tree, with valid/ready backpressure and wrap or saturate overflow handling.
module multi_operand_adder_pipe #(
  parameter int unsigned WIDTH     = 19,
  parameter int unsigned NUM_IN    = 3,
  parameter int unsigned OFFSET    = 102,
  parameter int unsigned OUT_WIDTH = 20,
  parameter bit          SAT       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned M      = NUM_IN + 1;
  localparam int unsigned LEVELS = $clog2(M);
  localparam int unsigned IW     = WIDTH + LEVELS;
  // Twice the operand count so pair reads at 2j+1 never index past the array.
  localparam int unsigned SLOTS  = 2 * M;

  function automatic int unsigned level_cnt(input int unsigned k);
    int unsigned n;
    n = M;
    for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [IW-1:0]        opnd   [SLOTS];
  logic [IW-1:0]        src    [LEVELS][SLOTS];
  logic [IW-1:0]        tree_d [LEVELS][SLOTS];
  logic [IW-1:0]        tree_q [LEVELS][SLOTS];
  logic [LEVELS-1:0]    vld_q;
  logic [LEVELS-1:0]    vld_in;
  logic                 advance;
  logic [IW-1:0]        true_sum;
  logic [OUT_WIDTH-1:0] res;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_ovf_q;
  logic                 out_valid_q;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign vld_in    = {vld_q[LEVELS-2:0], in_valid};
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

  always_comb begin : p_operands
    for (int unsigned i = 0; i < SLOTS; i++) opnd[i] = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) opnd[i] = IW'(in_data[i*WIDTH +: WIDTH]);
    opnd[NUM_IN] = IW'(OFFSET);
  end

  always_comb begin : p_tree
    src[0] = opnd;
    for (int unsigned k = 1; k < LEVELS; k++) src[k] = tree_q[k-1];
    for (int unsigned k = 0; k < LEVELS; k++) begin
      for (int unsigned j = 0; j < SLOTS; j++) tree_d[k][j] = '0;
      for (int unsigned j = 0; j < M; j++) begin
        if (2 * j + 1 < level_cnt(k)) begin
          tree_d[k][j] = src[k][2*j] + src[k][2*j+1];
        end else if (2 * j < level_cnt(k)) begin
          tree_d[k][j] = src[k][2*j];
        end
      end
    end
  end

  // Data of a stage only loads alongside a valid token, so bubbles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin : p_tree_regs
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        for (int unsigned j = 0; j < SLOTS; j++) tree_q[k][j] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_in;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        if (vld_in[k]) tree_q[k] <= tree_d[k];
      end
    end
  end

  assign true_sum = tree_q[LEVELS-1][0];

  if (IW > OUT_WIDTH) begin : g_ovf
    always_comb begin
      ovf = |true_sum[IW-1:OUT_WIDTH];
      res = true_sum[OUT_WIDTH-1:0];
      if (ovf && SAT) res = '1;
    end
  end else begin : g_no_ovf
    always_comb begin
      ovf = 1'b0;
      res = OUT_WIDTH'(true_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_out_regs
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= vld_q[LEVELS-1];
      if (vld_q[LEVELS-1]) begin
        out_data_q <= res;
        out_ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Scoreboard bench: default, saturating and a small NUM_IN=5 build of the adder pipeline.
module tb_multi_operand_adder_pipe;

  localparam int LAT  = 3;
  localparam int LATP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [56:0] in_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_ovf;
  logic [19:0] out_data;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [19:0] s_out_data;
  logic [39:0] p_data = '0;
  logic        p_valid = 1'b0, p_out_ready = 1'b1;
  logic        p_in_ready, p_out_valid, p_out_ovf;
  logic [11:0] p_out_data;

  multi_operand_adder_pipe dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  multi_operand_adder_pipe #(.SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf), .out_valid(s_out_valid), .out_ready(out_ready)
  );

  multi_operand_adder_pipe #(.WIDTH(8), .NUM_IN(5), .OFFSET(0), .OUT_WIDTH(12)) dut_par (
    .clk(clk), .rst(rst), .in_data(p_data), .in_valid(p_valid), .in_ready(p_in_ready),
    .out_data(p_out_data), .out_ovf(p_out_ovf), .out_valid(p_out_valid),
    .out_ready(p_out_ready)
  );

  typedef struct {
    logic [19:0] d;
    logic        o;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q_main[$], q_sat[$], q_par[$];
  int   n_chk = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string tag);
    n_chk++;
    n_err++;
    $display("FAIL %s unexpected: got out_valid=1, expected no result (cycle %0d)", tag, cyc);
  endtask

  task automatic cmp_item(input string tag, input exp_t e, input logic [19:0] d,
                          input logic o, input int lat);
    chk({tag, " data"}, 32'(d), 32'(e.d));
    chk({tag, " ovf"}, 32'(o), 32'(e.o));
    if (e.lat) chk({tag, " latency"}, cyc - e.cyc, lat);
  endtask

  // Monitors sample on the falling edge; a handshake completes on the next rising edge.
  logic [19:0] hold_d;
  bit          stall_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (stall_seen) chk("main hold", 32'(out_data), 32'(hold_d));
      if (out_ready) begin
        if (q_main.size() == 0) spurious("main");
        else cmp_item("main", q_main.pop_front(), out_data, out_ovf, LAT);
      end
      stall_seen = !out_ready;
      hold_d     = out_data;
    end else begin
      stall_seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && s_out_valid && out_ready) begin
      if (q_sat.size() == 0) spurious("sat");
      else cmp_item("sat", q_sat.pop_front(), s_out_data, s_out_ovf, LAT);
    end
  end

  always @(negedge clk) begin
    if (!rst && p_out_valid && p_out_ready) begin
      if (q_par.size() == 0) spurious("par");
      else cmp_item("par", q_par.pop_front(), 20'(p_out_data), p_out_ovf, LATP);
    end
  end

  task automatic send(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c,
                      input logic [19:0] ed, input logic eo, input logic [19:0] sd,
                      input logic so, input bit lat);
    int n = 0;
    bit acc;
    in_data  = {c, b, a};
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      n++;
      if (acc) begin
        q_main.push_back('{d: ed, o: eo, cyc: cyc, lat: lat});
        q_sat.push_back('{d: sd, o: so, cyc: cyc, lat: lat});
      end
      @(posedge clk);
      #1;
    end while (!acc && n < 100);
    if (!acc) chk("send timeout", 32'(acc), 32'd1);
  endtask

  task automatic p_send(input logic [39:0] d, input logic [11:0] e);
    int n = 0;
    bit acc;
    p_data  = d;
    p_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = p_in_ready;
      n++;
      if (acc) q_par.push_back('{d: 20'(e), o: 1'b0, cyc: cyc, lat: 1'b1});
      @(posedge clk);
      #1;
    end while (!acc && n < 100);
    if (!acc) chk("par send timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    p_valid  = 1'b0;
    while ((q_main.size() + q_sat.size() + q_par.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain pending", q_main.size() + q_sat.size() + q_par.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ovf", 32'(out_ovf), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    send(19'd1, 19'd2, 19'd3, 20'd108, 1'b0, 20'd108, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 16; k++)
          send(19'(i), 19'(j), 19'(k), 20'(i + j + k + 102), 1'b0,
               20'(i + j + k + 102), 1'b0, 1'b1);
    drain();

    send(19'd524287, 19'd524287, 19'd524287, 20'd524387, 1'b1, 20'd1048575, 1'b1, 1'b1);
    send(19'd524287, 19'd524186, 19'd0, 20'd1048575, 1'b0, 20'd1048575, 1'b0, 1'b1);
    drain();

    fork
      for (int i = 1; i <= 10; i++)
        send(19'(i), 19'(2 * i), 19'(3 * i), 20'(6 * i + 102), 1'b0,
             20'(6 * i + 102), 1'b0, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    send(19'd10, 19'd20, 19'd30, 20'd162, 1'b0, 20'd162, 1'b0, 1'b1);
    send(19'd1, 19'd1, 19'd1, 20'd105, 1'b0, 20'd105, 1'b0, 1'b1);
    send(19'd5, 19'd5, 19'd5, 20'd117, 1'b0, 20'd117, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    q_main.delete();
    q_sat.delete();
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst out_ovf", 32'(out_ovf), 32'd0);
    chk("async rst sat out_valid", 32'(s_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst held out_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(19'd0, 19'd0, 19'd0, 20'd102, 1'b0, 20'd102, 1'b0, 1'b1);
    drain();

    p_send(40'hFF_FFFF_FFFF, 12'd1275);
    p_send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 12'd15);
    p_send({8'd5, 8'd25, 8'd50, 8'd100, 8'd200}, 12'd380);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/multi_operand_adder_pipe.md
Name: multi_operand_adder_pipe

Overview:
- Parametrised, pipelined successor to the fixed three-input, constant-offset adder (`in1+in2+in3+102`).
- Sums NUM_IN unsigned operands plus a compile-time OFFSET through a registered binary adder tree.
- Adds a valid/ready handshake with full-pipeline backpressure, an overflow flag, and selectable wrap or saturate output.
- Sits between operand producers and a downstream consumer that may stall.

Parameters:
- WIDTH, 19, bit width of each input operand.
- NUM_IN, 3, number of input operands (legal range 2..16).
- OFFSET, 102, unsigned constant added to every sum; must be < 2^WIDTH.
- OUT_WIDTH, 20, output result width.
- SAT, 0, overflow handling: 0 = wrap (keep low OUT_WIDTH bits), 1 = clamp to 2^OUT_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  NUM_IN*WIDTH  packed operands; operand i = in_data[i*WIDTH +: WIDTH].
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept this cycle.
- out_data  output  OUT_WIDTH  result.
- out_ovf  output  1  true sum did not fit in OUT_WIDTH bits.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset: asynchronous on rst high. All stage valid bits, out_valid, out_data and out_ovf go to 0 immediately and stay 0 while rst is high. Data in flight at reset is discarded, never emitted.
- Operand count: M = NUM_IN+1, with OFFSET as the extra operand (included even when OFFSET = 0).
- Tree depth: LEVELS = clog2(M). Internal width IW = WIDTH+LEVELS; no internal truncation, so the internal sum is exact.
- Tree level k (1..LEVELS) adds adjacent pairs from level k-1 and registers the results. An odd leftover operand passes through registered, unchanged.
- Output stage (registered):
  - true_sum >= 2^OUT_WIDTH: out_ovf=1 and out_data = SAT ? all-ones : true_sum[OUT_WIDTH-1:0].
  - Otherwise out_ovf=0 and out_data = true_sum.
  - If IW <= OUT_WIDTH, out_ovf is constant 0.
- Latency: LAT = LEVELS+1 cycles from the accepting edge (in_valid && in_ready) to out_valid=1. Defaults give LAT = 3.
- Each stage carries a valid bit; out_valid is the last stage's valid.
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance (combinational; no dependence on in_valid).
- When advance=0, every stage register, including the valid bits, holds. out_data and out_ovf stay stable while out_valid && !out_ready.
- When advance=1, every stage shifts by one. Empty (valid=0) stages shift as bubbles; stage-1 valid loads in_valid.
- Throughput: one result per cycle with out_ready held high. No bubbles are inserted by the block.
- Simultaneous in/out handshake in the same cycle with a full pipeline: both complete, and occupancy is unchanged.
- Data registers of invalid stages may hold stale values, but out_data must be 0 after reset until the first valid result.
- Wrap-around of operands is not checked; all inputs are treated as unsigned.

Test Plan:
- Basic (defaults): operands 1,2,3 with in_valid=1 and out_ready=1 for one cycle -> after 3 cycles out_valid=1, out_data=108, out_ovf=0, for exactly one cycle.
- Exhaustive low range: all i,j,k in 0..15, issued back-to-back -> each result equals i+j+k+102 in issue order. 4096 results at one per cycle, no gaps, first result 3 cycles after first issue.
- Overflow, SAT=0: all operands 524287 -> out_ovf=1, out_data=524387 (1572963 mod 2^20).
- Overflow, SAT=1: all operands 524287 -> out_ovf=1, out_data=1048575. Sum exactly 1048575 (e.g. 524287, 524186, 0) -> out_ovf=0.
- Backpressure: stream 10 sets, drop out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, out_data held stable, no loss or duplication, order preserved.
- Reset mid-flight: assert rst asynchronously with 3 results in flight -> out_valid=0 and out_data=0 immediately. After release, no stale results appear and a new set 0,0,0 yields 102 after 3 cycles.
- Parametrised build: NUM_IN=5, WIDTH=8, OFFSET=0, OUT_WIDTH=12 -> LAT=4; operands 255×5 -> out_data=1275, out_ovf=0.
